// File: rtl/mc_alu.sv
// mc_alu -- clocked ALU for the multicycle MIPS datapath.
//
// Single-cycle operations (AND, OR, ADD, SUB, SLT, NOR) register their
// result on the accepting edge. MULTU runs as a shift-add loop and DIVU as a
// restoring divider. Each one retires one bit per cycle, and the final value
// is written to result/hi only on the last iteration.
//
// Optional feature macro: MC_ALU_DIV_EN. When it is defined, the divider is
// built. When it is undefined, DIVU decodes as an illegal opcode.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high; aborts any operation
//   start   in   issue request, sampled only while busy=0
//   op      in   [OPW-1:0] opcode
//   a, b    in   [WIDTH-1:0] operands, latched on acceptance
//   result  out  [WIDTH-1:0] registered result (LO / quotient)
//   hi      out  [WIDTH-1:0] registered HI (product upper half / remainder)
//   zero    out  result == 0
//   busy    out  iterative operation in progress
//   done    out  one-cycle pulse when result/hi were updated
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
`ifdef MC_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic              done_q, done_d;

    // Iteration working set. For MULTU, work_hi is the partial-product upper
    // half and work_lo holds the multiplier, shifting out LSB-first. For
    // DIVU, work_hi is the partial remainder and work_lo holds the dividend,
    // shifting out MSB-first while quotient bits shift in. opnd holds the
    // multiplicand or the divisor.
    logic [WIDTH-1:0]  work_hi_q, work_hi_d;
    logic [WIDTH-1:0]  work_lo_q, work_lo_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi_nx, mul_lo_nx;
    logic              last_iter;

`ifdef MC_ALU_DIV_EN
    logic [WIDTH:0]    div_shift, div_trial;
    logic [WIDTH-1:0]  div_rem_nx, div_quo_nx;
`endif

    function automatic logic [WIDTH-1:0] alu_single(
        input logic [OPW-1:0]   opc,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (opc)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_NOR:  r = ~(x | y);
            default: r = '0;   // illegal opcodes write zero
        endcase
        return r;
    endfunction

    always_comb begin
        // One shift-add step: add the multiplicand if the multiplier LSB is
        // set, then shift the {hi, lo} pair right by one bit.
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], work_lo_q[WIDTH-1:1]};

`ifdef MC_ALU_DIV_EN
        // One restoring step: shift the next dividend bit into the remainder
        // and subtract the divisor. Keep the difference only if it is
        // non-negative. A zero divisor always subtracts, so the quotient
        // becomes all ones and the remainder ends up equal to the dividend.
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (!div_trial[WIDTH]) begin
            div_rem_nx = div_trial[WIDTH-1:0];
            div_quo_nx = {work_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_nx = div_shift[WIDTH-1:0];
            div_quo_nx = {work_lo_q[WIDTH-2:0], 1'b0};
        end
`endif

        last_iter = (cnt_q == CNT_W'(WIDTH - 1));

        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        hi_d      = hi_q;
        done_d    = 1'b0;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opnd_d    = opnd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            state_d   = S_MUL;
                            cnt_d     = '0;
                            work_hi_d = '0;
                            work_lo_d = b;
                            opnd_d    = a;
                        end
`ifdef MC_ALU_DIV_EN
                        OP_DIVU: begin
                            state_d   = S_DIV;
                            cnt_d     = '0;
                            work_hi_d = '0;
                            work_lo_d = a;
                            opnd_d    = b;
                        end
`endif
                        default: begin
                            result_d = alu_single(op, a, b);
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                work_hi_d = mul_hi_nx;
                work_lo_d = mul_lo_nx;
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    result_d = mul_lo_nx;
                    hi_d     = mul_hi_nx;
                    done_d   = 1'b1;
                end
            end
`ifdef MC_ALU_DIV_EN
            S_DIV: begin
                work_hi_d = div_rem_nx;
                work_lo_d = div_quo_nx;
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    result_d = div_quo_nx;
                    hi_d     = div_rem_nx;
                    done_d   = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            done_q   <= done_d;
        end
    end

    // The working set is always loaded before use, so it needs no reset.
    always_ff @(posedge clk) begin
        work_hi_q <= work_hi_d;
        work_lo_q <= work_lo_d;
        opnd_q    <= opnd_d;
    end

    assign result = result_q;
    assign hi     = hi_q;
    assign zero   = (result_q == '0);
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    logic        clk;
    logic        reset;

    logic        start32;
    logic [3:0]  op32;
    logic [31:0] a32, b32;
    logic [31:0] result32, hi32;
    logic        zero32, busy32, done32;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic [7:0]  result8, hi8;
    logic        zero8, busy8, done8;

    int total;
    int passes;
    int fails;

    mc_alu #(.WIDTH(32), .OPW(4)) u32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .result(result32), .hi(hi32), .zero(zero32), .busy(busy32), .done(done32)
    );

    mc_alu #(.WIDTH(8), .OPW(4)) u8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .result(result8), .hi(hi8), .zero(zero8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the 32-bit request lines between edges, then sample 1 ns after
    // the next rising edge.
    task automatic step32(input logic s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start32 = s; op32 = o; a32 = x; b32 = y;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic s, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start8 = s; op8 = o; a8 = x; b8 = y;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done32(input int maxc, output int took);
        took = maxc + 1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            start32 = 1'b0;
            @(posedge clk);
            #1;
            if (done32) begin
                took = i;
                break;
            end
        end
    endtask

    task automatic wait_done8(input int maxc, output int took);
        took = maxc + 1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            @(posedge clk);
            #1;
            if (done8) begin
                took = i;
                break;
            end
        end
    endtask

    initial begin
        int first_done;
        int leaked;
        int took;

        total = 0; passes = 0; fails = 0;
        reset = 1'b1;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result32, 0);
        check("rst_hi", hi32, 0);
        check("rst_zero", zero32, 1);
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst8_result", result8, 0);
        check("rst8_zero", zero8, 1);

        @(negedge clk);
        reset = 1'b0;

        // Back-to-back single-cycle operations with a=7, b=3.
        step32(1, OP_AND, 32'd7, 32'd3);
        check("and_res", result32, 3);
        check("and_done", done32, 1);
        check("and_busy", busy32, 0);
        step32(1, OP_OR, 32'd7, 32'd3);
        check("or_res", result32, 7);
        check("or_done", done32, 1);
        step32(1, OP_ADD, 32'd7, 32'd3);
        check("add_res", result32, 10);
        check("add_zero", zero32, 0);
        step32(1, OP_SUB, 32'd7, 32'd3);
        check("sub_res", result32, 4);
        check("sub_done", done32, 1);
        check("sub_busy", busy32, 0);

        step32(1, OP_SUB, 32'd3, 32'd7);
        check("sub_neg", result32, 32'hFFFF_FFFC);
        step32(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        check("slt_signed", result32, 1);
        step32(1, OP_SLT, 32'd1, 32'hFFFF_FFFF);
        check("slt_false", result32, 0);
        step32(1, OP_NOR, 32'h0F0F_0000, 32'h0000_00F0);
        check("nor_res", result32, 32'hF0F0_FF0F);
        step32(1, OP_SUB, 32'd5, 32'd5);
        check("sub_eq_res", result32, 0);
        check("sub_eq_zero", zero32, 1);
        step32(1, 4'b0011, 32'd9, 32'd9);
        check("illegal_res", result32, 0);
        check("illegal_done", done32, 1);
        check("illegal_hi", hi32, 0);

        // MULTU 0xFFFFFFFF * 2. A start issued mid-operation and another on
        // the completing edge must both be ignored.
        step32(1, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("mul_busy", busy32, 1);
        check("mul_accept_done", done32, 0);
        first_done = 0;
        leaked = 0;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            if (j == 10) begin
                start32 = 1'b1; op32 = OP_AND; a32 = 32'hFFFF; b32 = 32'hFFFF;
            end else if (j == 32) begin
                start32 = 1'b1; op32 = OP_ADD; a32 = 32'd2; b32 = 32'd2;
            end else begin
                start32 = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done32 && first_done == 0) first_done = j;
            if (j < 32 && (result32 !== 32'd0 || hi32 !== 32'd0)) leaked = 1;
        end
        check("mul_latency", first_done, 32);
        check("mul_no_leak", leaked, 0);
        check("mul_lo", result32, 32'hFFFF_FFFE);
        check("mul_hi", hi32, 1);
        check("mul_busy_end", busy32, 0);
        // start is still held; it is accepted on the next edge.
        step32(1, OP_ADD, 32'd2, 32'd2);
        check("post_mul_add", result32, 4);
        check("post_mul_done", done32, 1);
        check("add_hi_kept", hi32, 1);

        step32(1, OP_DIVU, 32'd100, 32'd7);
`ifdef MC_ALU_DIV_EN
        check("div_busy", busy32, 1);
        wait_done32(40, took);
        check("div_latency", took, 32);
        check("div_quo", result32, 14);
        check("div_rem", hi32, 2);
        step32(1, OP_DIVU, 32'd9, 32'd0);
        wait_done32(40, took);
        check("div0_latency", took, 32);
        check("div0_quo", result32, 32'hFFFF_FFFF);
        check("div0_rem", hi32, 9);
`else
        check("divu_off_res", result32, 0);
        check("divu_off_done", done32, 1);
        check("divu_off_busy", busy32, 0);
        check("divu_off_hi", hi32, 1);
        step32(1, OP_DIVU, 32'd9, 32'd0);
        check("divu_off_res2", result32, 0);
        check("divu_off_busy2", busy32, 0);
`endif

        // Put a non-zero value on result before the abort test.
        step32(1, OP_OR, 32'h55, 32'h0);
        check("pre_abort_res", result32, 32'h55);

        // Reset 10 cycles into a MULTU.
        step32(1, OP_MULTU, 32'd3, 32'd5);
        for (int j = 1; j <= 9; j++) step32(0, OP_AND, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy32, 0);
        check("abort_result", result32, 0);
        check("abort_hi", hi32, 0);
        check("abort_zero", zero32, 1);
        check("abort_done", done32, 0);
        @(negedge clk);
        reset = 1'b0;
        step32(0, OP_AND, 32'd0, 32'd0);
        check("abort_no_done", done32, 0);
        step32(1, OP_ADD, 32'd2, 32'd2);
        check("abort_add", result32, 4);
        check("abort_add_done", done32, 1);

        // Reset and start on the same edge: the request is dropped.
        @(negedge clk);
        reset = 1'b1; start32 = 1'b1; op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1;
        @(posedge clk);
        #1;
        check("rst_start_res", result32, 0);
        check("rst_start_done", done32, 0);
        @(negedge clk);
        reset = 1'b0; start32 = 1'b0;

        // WIDTH=8 multiply.
        step8(1, OP_MULTU, 8'hFF, 8'hFF);
        check("mul8_busy", busy8, 1);
        wait_done8(12, took);
        check("mul8_latency", took, 8);
        check("mul8_lo", result8, 8'h01);
        check("mul8_hi", hi8, 8'hFE);
        step8(0, OP_AND, 8'h0, 8'h0);
        check("mul8_done_pulse", done8, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
